// File: rtl/shift_seq_ctrl_pkg.sv
// rtl/shift_seq_ctrl_pkg.sv - shared types and constants for the shift sequencer
// Purpose: operation and state encodings plus datapath width.
// Ports: none (package shift_seq_pkg).
// Optional feature macro used elsewhere in this slice: SHIFT_SEQ_ABORT_EN.
package shift_seq_pkg;

    localparam int XLEN_C = 32;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_PASS = 2'b10,
        OP_SRA  = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } seq_state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// rtl/shift_seq_ctrl_if.sv - request/result bundle of the shift sequencer
// Purpose: groups the start/busy/done handshake, operands and result.
// Signals: start, op, data_in, shift_amount (requester -> sequencer);
//          busy, done, data_out (sequencer -> requester);
//          abort (requester -> sequencer, only with SHIFT_SEQ_ABORT_EN).
// Modports: master = requester side, slave = sequencer side.
interface shift_seq_ctrl_if;
    import shift_seq_pkg::*;

    logic               start;
    shift_op_e          op;
    logic [XLEN_C-1:0]  data_in;
    logic [4:0]         shift_amount;
    logic               busy;
    logic               done;
    logic [XLEN_C-1:0]  data_out;
`ifdef SHIFT_SEQ_ABORT_EN
    logic               abort;

    modport master (output start, op, data_in, shift_amount, abort,
                    input  busy, done, data_out);
    modport slave  (input  start, op, data_in, shift_amount, abort,
                    output busy, done, data_out);
`else
    modport master (output start, op, data_in, shift_amount,
                    input  busy, done, data_out);
    modport slave  (input  start, op, data_in, shift_amount,
                    output busy, done, data_out);
`endif

endinterface

// File: rtl/shift_seq_ctrl_step.sv
// rtl/shift_seq_ctrl_step.sv - one narrow combinational shift stage
// Purpose: shifts din by 0..STEP bits; right shifts take vacated bits from fill.
// Ports: din (operand), op (shift_op_e), amt (0..STEP), fill (bit shifted in
//        on right shifts), dout (result). OP_PASS returns din unchanged.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int STEP = 4,
    localparam int AW  = $clog2(STEP + 1)
) (
    input  logic [XLEN_C-1:0] din,
    input  shift_op_e         op,
    input  logic [AW-1:0]     amt,
    input  logic              fill,
    output logic [XLEN_C-1:0] dout
);

    always_comb begin
        dout = din;
        case (op)
            OP_SLL:         dout = din << amt;
            // Vacated MSBs are exactly the bits cleared by shifting all-ones right.
            OP_SRL, OP_SRA: dout = (din >> amt) | (fill ? ~({XLEN_C{1'b1}} >> amt) : '0);
            OP_PASS:        dout = din;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - multi-cycle SLL/SRL/SRA sequencer, STEP bits per cycle
// Purpose: accepts one request, shifts it iteratively through shift_step and
//          holds the result in data_out until the next completion.
// Ports: clk (rising edge), rst (async, active high),
//        bus (shift_seq_ctrl_if.slave: start/op/data_in/shift_amount in,
//             busy/done/data_out out, abort in when SHIFT_SEQ_ABORT_EN is defined).
// Macro: SHIFT_SEQ_ABORT_EN adds abort; abort in SHIFT returns to IDLE with no done.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    shift_seq_ctrl_if.slave  bus
);

    localparam int         AW     = $clog2(STEP + 1);
    localparam logic [4:0] STEP_V = 5'(STEP);

    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] work_q;
    logic [XLEN-1:0] step_out;
    logic [XLEN-1:0] data_out_q;
    shift_op_e       op_q;
    logic [4:0]      rem_q;
    logic [4:0]      k;
    logic            sign_q;
    logic            accept;
    logic            abort_req;
    logic            busy_c;
    logic            done_c;

`ifdef SHIFT_SEQ_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    // Requests are only looked at when no shift is running.
    assign accept = bus.start && (state_q == IDLE || state_q == DONE);
    assign k      = (rem_q > STEP_V) ? STEP_V : rem_q;

    shift_step #(.STEP(STEP)) u_step (
        .din  (work_q),
        .op   (op_q),
        .amt  (k[AW-1:0]),
        .fill (op_q == OP_SRA && sign_q),
        .dout (step_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start)
                    state_d = (bus.op == OP_PASS || bus.shift_amount == 5'd0) ? DONE : SHIFT;
                else
                    state_d = IDLE;
            end
            SHIFT: begin
                if (abort_req)       state_d = IDLE;
                else if (rem_q == k) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state_q)
            SHIFT:   busy_c = 1'b1;
            DONE:    done_c = 1'b1;
            default: ;
        endcase
    end

    // data_out is loaded only on the edge that enters DONE, so it is already
    // valid during the done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q     <= '0;
            op_q       <= OP_SLL;
            rem_q      <= 5'd0;
            sign_q     <= 1'b0;
            data_out_q <= '0;
        end else if (accept) begin
            work_q <= bus.data_in;
            op_q   <= bus.op;
            rem_q  <= bus.shift_amount;
            sign_q <= bus.data_in[XLEN-1];
            if (state_d == DONE) data_out_q <= bus.data_in;
        end else if (state_q == SHIFT && !abort_req) begin
            work_q <= step_out;
            rem_q  <= rem_q - k;
            if (state_d == DONE) data_out_q <= step_out;
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed self-checking bench for shift_seq_ctrl
module tb_shift_seq_ctrl;
    import shift_seq_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    shift_seq_ctrl_if bus_if ();

    shift_seq_ctrl #(.XLEN(32), .STEP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, then wait (bounded) for done; ends in the done cycle.
    task automatic run_req(input string tag, input shift_op_e op, input logic [31:0] d,
                           input logic [4:0] amt, input int exp_busy, input logic [31:0] exp_out);
        int nb;
        int overlap;
        bit seen;
        bus_if.start        = 1'b1;
        bus_if.op           = op;
        bus_if.data_in      = d;
        bus_if.shift_amount = amt;
        tick();
        bus_if.start = 1'b0;
        nb      = 0;
        overlap = 0;
        seen    = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus_if.busy && bus_if.done) overlap++;
            if (bus_if.done) seen = 1'b1;
            else begin
                if (bus_if.busy) nb++;
                tick();
            end
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " busy_cycles"}, nb, exp_busy);
        check({tag, " busy_done_overlap"}, overlap, 0);
        check({tag, " data_out"}, bus_if.data_out, exp_out);
    endtask

    initial begin
        int cnt;
        total = 0;
        bad   = 0;
        rst                 = 1'b1;
        bus_if.start        = 1'b0;
        bus_if.op           = OP_SLL;
        bus_if.data_in      = '0;
        bus_if.shift_amount = '0;
`ifdef SHIFT_SEQ_ABORT_EN
        bus_if.abort        = 1'b0;
`endif
        tick();
        tick();
        check("reset busy", 32'(bus_if.busy), 0);
        check("reset done", 32'(bus_if.done), 0);
        check("reset data_out", bus_if.data_out, 32'h0);
        rst = 1'b0;
        tick();

        run_req("sra_4", OP_SRA, 32'h8000_0000, 5'd4, 1, 32'hF800_0000);
        tick();
        check("after_done done", 32'(bus_if.done), 0);
        check("after_done busy", 32'(bus_if.busy), 0);

        run_req("srl_31", OP_SRL, 32'h8000_0000, 5'd31, 8, 32'h0000_0001);
        tick();

        run_req("sll_0", OP_SLL, 32'h0000_0001, 5'd0, 0, 32'h0000_0001);
        run_req("b2b_sra_31", OP_SRA, 32'hF000_0000, 5'd31, 8, 32'hFFFF_FFFF);
        tick();

        run_req("pass", OP_PASS, 32'h1234_5678, 5'd7, 0, 32'h1234_5678);
        tick();
        run_req("sra_pos_8", OP_SRA, 32'h7FFF_0000, 5'd8, 2, 32'h007F_FF00);
        tick();
        run_req("srl_3", OP_SRL, 32'hF000_0000, 5'd3, 1, 32'h1E00_0000);
        tick();
        run_req("sll_16", OP_SLL, 32'hA5A5_A5A5, 5'd16, 4, 32'hA5A5_0000);
        tick();

        // start during SHIFT must be ignored
        bus_if.start        = 1'b1;
        bus_if.op           = OP_SLL;
        bus_if.data_in      = 32'h0000_0001;
        bus_if.shift_amount = 5'd8;
        tick();
        bus_if.start = 1'b0;
        check("mid busy1", 32'(bus_if.busy), 1);
        check("mid hold data_out", bus_if.data_out, 32'hA5A5_0000);
        bus_if.start        = 1'b1;
        bus_if.op           = OP_SRL;
        bus_if.data_in      = 32'hFFFF_FFFF;
        bus_if.shift_amount = 5'd4;
        tick();
        bus_if.start = 1'b0;
        check("mid busy2", 32'(bus_if.busy), 1);
        tick();
        check("mid done", 32'(bus_if.done), 1);
        check("mid data_out", bus_if.data_out, 32'h0000_0100);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_if.busy || bus_if.done) cnt++;
        end
        check("mid second_not_serviced", cnt, 0);

`ifdef SHIFT_SEQ_ABORT_EN
        bus_if.start        = 1'b1;
        bus_if.op           = OP_SRL;
        bus_if.data_in      = 32'hFFFF_FFFF;
        bus_if.shift_amount = 5'd16;
        tick();
        bus_if.start = 1'b0;
        check("abort busy1", 32'(bus_if.busy), 1);
        tick();
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0;
        check("abort busy", 32'(bus_if.busy), 0);
        check("abort done", 32'(bus_if.done), 0);
        check("abort data_out", bus_if.data_out, 32'h0000_0100);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_if.done) cnt++;
        end
        check("abort no_done", cnt, 0);
`endif

        // reset in the middle of a shift
        bus_if.start        = 1'b1;
        bus_if.op           = OP_SLL;
        bus_if.data_in      = 32'h0000_0001;
        bus_if.shift_amount = 5'd20;
        tick();
        bus_if.start = 1'b0;
        tick();
        check("rst pre busy", 32'(bus_if.busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst busy", 32'(bus_if.busy), 0);
        check("rst done", 32'(bus_if.done), 0);
        check("rst data_out", bus_if.data_out, 32'h0);
        #2;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_if.done || bus_if.busy) cnt++;
        end
        check("rst no_later_activity", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Multi-cycle sequencer for the integer shift datapath: accepts one SLL/SRL/SRA request, then applies it iteratively at STEP bits per cycle through a narrow shift stage instead of a full 32-bit barrel shifter. Sits beside the ALU in the area-reduced core variant. Uses a start/busy/done handshake and holds the result until the next accepted request.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
STEP, 4, maximum shift distance per cycle; legal values 1, 2, 4, 8, 16.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request strobe; sampled only when the block can accept
op  in  2  2'b00 SLL, 2'b01 SRL, 2'b11 SRA; 2'b10 = pass-through (result = data_in)
data_in  in  XLEN  operand
shift_amount  in  5  shift distance 0..31
busy  out  1  high while a request is in progress (SHIFT state)
done  out  1  one-cycle pulse: data_out valid and updated
data_out  out  XLEN  result register; holds its value until the next completion

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, data_out=32'h0, remaining count=0. Any request in flight is discarded.
- States: IDLE, SHIFT, DONE.
- Accept: start=1 in IDLE or DONE → latch data_in into the work register; latch op, shift_amount into remaining, and sign=data_in[31].
  - Next state is SHIFT if shift_amount≠0 or op=2'b10 goes straight to DONE; shift_amount=0 also goes to DONE.
- SHIFT: each cycle applies k=min(STEP, remaining) to the work register and sets remaining -= k.
  - SLL fills with 0s; SRL fills with 0s; SRA fills with the latched sign.
  - When remaining reaches 0 after the update, next state=DONE.
- DONE: done=1 for exactly this cycle; data_out = work register, registered on entry to DONE.
  - With no start, next state=IDLE. With start, accept as in IDLE (back-to-back).
- Latency: N=ceil(shift_amount/STEP) SHIFT cycles; done asserts N+1 cycles after the accepting edge (1 cycle for amount 0 or pass-through).
- start while busy=1: ignored, with no effect on state or operands. Inputs are not used after acceptance.
- busy=1 only in SHIFT; done=1 only in DONE; busy and done are never both 1.
- data_out changes only on entry to DONE (or on reset).
- Reset asserted mid-SHIFT: immediate return to IDLE; done is not emitted.

Optional Feature:
SHIFT_SEQ_ABORT_EN
- Defined: adds input port abort (1 bit). abort=1 in SHIFT → next state IDLE, no done pulse, data_out keeps its previous value. abort is ignored in IDLE and DONE. If abort and start are both high in DONE, start wins.
- Undefined: no abort port; a shift always runs to completion.

Decomposition:
- Package shift_seq_pkg:
  - shift_op_e enum (OP_SLL=2'b00, OP_SRL=2'b01, OP_PASS=2'b10, OP_SRA=2'b11)
  - seq_state_e enum (IDLE, SHIFT, DONE)
  - XLEN_C=32 localparam
- Sub-module shift_step: combinational single stage. Shifts by 0..STEP under shift_op_e with an explicit fill bit. Instantiated once.

Test Plan:
- STEP=4, SRA, data_in=32'h8000_0000, shift_amount=4 → busy for 1 cycle; done 2 cycles after accept; data_out=32'hF800_0000.
- SRL, data_in=32'h8000_0000, shift_amount=31 → 8 busy cycles; done at cycle 9; data_out=32'h0000_0001.
- SLL, data_in=32'h0000_0001, shift_amount=0 → no busy cycles; done after 1 cycle; data_out=32'h0000_0001. Back-to-back start in the DONE cycle with SRA 32'hF000_0000 by 31 → data_out=32'hFFFF_FFFF.
- start pulsed mid-shift with different operands → ignored; the original result completes and the second request is never serviced.
- rst pulsed during SHIFT (SLL 32'h1 by 20) → busy=0, done=0, data_out=0 immediately, with no later done pulse.
- SHIFT_SEQ_ABORT_EN: abort in the 2nd SHIFT cycle of SRL 32'hFFFF_FFFF by 16 → IDLE next cycle, no done, data_out unchanged.
